// File: rtl/vanilla_idiv_seq.sv
// -----------------------------------------------------------------------------
// vanilla_idiv_seq
// Sequential integer divider (restoring shift-subtract, one quotient bit per
// cycle) supporting signed/unsigned divide and remainder.
//
// Ports
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   v_i        : request valid; accepted when v_i & ready_o
//   ready_o    : high only in IDLE while kill_i is low
//   op_i       : 0=DIV, 1=DIVU, 2=REM, 3=REMU
//   rs1_i      : dividend
//   rs2_i      : divisor
//   rd_i       : destination tag, latched at accept
//   kill_i     : abort in-flight operation (returns to IDLE next edge)
//   v_o        : result valid (DONE state)
//   yumi_i     : result consumed; ignored unless v_o is high
//   result_o   : quotient or remainder per op
//   rd_o       : destination tag of the operation
//
// Configuration macro
//   VANILLA_IDIV_ZERO_FASTPATH_EN : when defined, a divide by zero skips the
//   iteration and sign-fix states and presents its result one cycle after
//   accept. Undefined (default): divide by zero takes the full latency.
// -----------------------------------------------------------------------------
module vanilla_idiv_seq #(
    parameter int width_p        = 32,
    parameter int reg_id_width_p = 5
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [1:0]                op_i,
    input  logic [width_p-1:0]        rs1_i,
    input  logic [width_p-1:0]        rs2_i,
    input  logic [reg_id_width_p-1:0] rd_i,
    input  logic                      kill_i,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [width_p-1:0]        result_o,
    output logic [reg_id_width_p-1:0] rd_o
);

    localparam int cnt_w_lp = $clog2(width_p) + 1;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    localparam logic [width_p-1:0]        zero_lp      = {width_p{1'b0}};
    localparam logic [width_p-1:0]        ones_lp      = {width_p{1'b1}};
    localparam logic [width_p-1:0]        one_lp       = {{(width_p-1){1'b0}}, 1'b1};
    localparam logic [cnt_w_lp-1:0]       cnt_zero_lp  = {cnt_w_lp{1'b0}};
    localparam logic [cnt_w_lp-1:0]       cnt_one_lp   = {{(cnt_w_lp-1){1'b0}}, 1'b1};
    localparam logic [cnt_w_lp-1:0]       cnt_last_lp  = cnt_w_lp'(width_p - 1);
    localparam logic [reg_id_width_p-1:0] rd_zero_lp   = {reg_id_width_p{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Pick quotient or remainder according to the operation code.
    function automatic logic [width_p-1:0] sel_result(
        input logic [1:0]         op,
        input logic [width_p-1:0] quo,
        input logic [width_p-1:0] rem
    );
        logic [width_p-1:0] res;
        case (op)
            OP_DIV:  res = quo;
            OP_DIVU: res = quo;
            OP_REM:  res = rem;
            OP_REMU: res = rem;
            default: res = quo;
        endcase
        return res;
    endfunction

    // Two's-complement negate when the flag is set.
    function automatic logic [width_p-1:0] cond_neg(
        input logic               neg,
        input logic [width_p-1:0] val
    );
        logic [width_p-1:0] res;
        if (neg) begin
            res = ~val + one_lp;
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [cnt_w_lp-1:0]    cnt_r;

    // Operand / working registers (not reset; only observed through DONE).
    logic [1:0]             op_r;
    logic                   neg_q_r;
    logic                   neg_rem_r;
    logic                   div_zero_r;
    logic [width_p-1:0]     dividend_r;
    logic [width_p-1:0]     divisor_r;
    logic [width_p-1:0]     quo_r;
    logic [width_p-1:0]     rem_r;

    logic                   accept_s;
    logic                   signed_op_s;
    logic                   fast_zero_s;
    logic [width_p-1:0]     rs1_abs_s;
    logic [width_p-1:0]     rs2_abs_s;
    logic [width_p:0]       rem_shift_s;
    logic                   ge_s;
    logic [width_p-1:0]     diff_s;
    logic [width_p-1:0]     rem_step_s;
    logic [width_p-1:0]     quo_step_s;
    logic [width_p-1:0]     quo_fix_s;
    logic [width_p-1:0]     rem_fix_s;

    assign ready_o     = (state_r == IDLE) && !kill_i;
    assign v_o         = (state_r == DONE);
    assign accept_s    = v_i && ready_o;
    assign signed_op_s = (op_i == OP_DIV) || (op_i == OP_REM);

`ifdef VANILLA_IDIV_ZERO_FASTPATH_EN
    assign fast_zero_s = (rs2_i == zero_lp);
`else
    assign fast_zero_s = 1'b0;
`endif

    // Magnitudes of the incoming operands (signed ops only).
    always_comb begin
        rs1_abs_s = cond_neg(signed_op_s && rs1_i[width_p-1], rs1_i);
        rs2_abs_s = cond_neg(signed_op_s && rs2_i[width_p-1], rs2_i);
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The partial remainder
    // is always below the divisor, so the shifted value needs one extra bit
    // for the compare but the difference fits in width_p bits.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[width_p-1]};
        ge_s        = (rem_shift_s >= {1'b0, divisor_r});
        diff_s      = rem_shift_s[width_p-1:0] - divisor_r;
        if (ge_s) begin
            rem_step_s = diff_s;
        end else begin
            rem_step_s = rem_shift_s[width_p-1:0];
        end
        quo_step_s = {quo_r[width_p-2:0], ge_s};
    end

    // Sign correction; divide by zero bypasses it and returns all-ones
    // quotient and the untouched dividend as remainder.
    always_comb begin
        if (div_zero_r) begin
            quo_fix_s = ones_lp;
            rem_fix_s = dividend_r;
        end else begin
            quo_fix_s = cond_neg(neg_q_r, quo_r);
            rem_fix_s = cond_neg(neg_rem_r, rem_r);
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (fast_zero_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == cnt_last_lp) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX: begin
                if (kill_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DONE: begin
                if (kill_i || yumi_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, iteration counter and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            cnt_r    <= cnt_zero_lp;
            result_o <= zero_lp;
            rd_o     <= rd_zero_lp;
        end else begin
            state_r <= state_nxt_s;
            // Counter only advances while iterating; cleared everywhere else,
            // which also clears it on accept.
            if ((state_r == CALC) && (state_nxt_s == CALC)) begin
                cnt_r <= cnt_r + cnt_one_lp;
            end else begin
                cnt_r <= cnt_zero_lp;
            end
            if (accept_s) begin
                rd_o <= rd_i;
            end
            if ((state_r == FIX) && !kill_i) begin
                result_o <= sel_result(op_r, quo_fix_s, rem_fix_s);
            end else if (accept_s && fast_zero_s) begin
                result_o <= sel_result(op_i, ones_lp, rs1_i);
            end
        end
    end

    // Operand capture at accept and shift-subtract iteration in CALC.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            op_r       <= op_i;
            dividend_r <= rs1_i;
            divisor_r  <= rs2_abs_s;
            quo_r      <= rs1_abs_s;
            rem_r      <= zero_lp;
            neg_q_r    <= signed_op_s && (rs1_i[width_p-1] ^ rs2_i[width_p-1]);
            neg_rem_r  <= signed_op_s && rs1_i[width_p-1];
            div_zero_r <= (rs2_i == zero_lp);
        end else if (state_r == CALC) begin
            quo_r <= quo_step_s;
            rem_r <= rem_step_s;
        end
    end

endmodule

// File: doc/vanilla_idiv_seq.md
VANILLA_IDIV_SEQ -- requirements
Module: vanilla_idiv_seq

Interface
REQ-001 SHALL have parameter width_p, default 32, operand/result width.
REQ-002 SHALL have parameter reg_id_width_p, default 5, destination tag width.
REQ-003 SHALL have port clk_i, input, 1, sole clock.
REQ-004 SHALL have port reset_n_i, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port v_i, input, 1, divide request valid.
REQ-006 SHALL have port ready_o, output, 1, request accepted when v_i & ready_o.
REQ-007 SHALL have port op_i, input, 2, idiv_op_e (eDIV, eDIVU, eREM, eREMU).
REQ-008 SHALL have ports rs1_i, rs2_i, input, width_p, dividend and divisor.
REQ-009 SHALL have port rd_i, input, reg_id_width_p, destination register tag.
REQ-010 SHALL have port kill_i, input, 1, abort of the in-flight operation (pipeline flush).
REQ-011 SHALL have port v_o, output, 1, result valid.
REQ-012 SHALL have port yumi_i, input, 1, result consumed; legal only when v_o=1.
REQ-013 SHALL have port result_o, output, width_p, quotient or remainder per op.
REQ-014 SHALL have port rd_o, output, reg_id_width_p, tag latched at accept.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-016 ready_o SHALL be 1 only in IDLE with kill_i=0.
REQ-017 On accept: latch op, rd and operands; for signed ops, take absolute values and record the quotient sign (sign(rs1) xor sign(rs2)) and the remainder sign (sign(rs1)); transition to CALC; clear the iteration counter.
REQ-018 CALC SHALL perform restoring shift-subtract, one quotient bit per cycle, for exactly width_p cycles, using a counter of $clog2(width_p)+1 bits; after the last iteration it SHALL go to FIX.
REQ-019 FIX SHALL conditionally two's-complement negate the quotient and remainder per the recorded signs, select the result per op, and go to DONE.
REQ-020 In DONE, v_o SHALL be 1 and result_o/rd_o SHALL be stable until yumi_i; on yumi_i the FSM SHALL go to IDLE (a new request is not accepted in the same cycle).
REQ-021 Latency: v_o SHALL first rise exactly width_p+2 cycles after the accept edge.
REQ-022 Divisor zero: quotient SHALL be all ones and remainder SHALL be the original rs1, for both signed and unsigned ops, with no sign fix applied.
REQ-023 Signed overflow (rs1=-2^(width_p-1), rs2=-1): quotient SHALL equal rs1 and remainder SHALL be 0.
REQ-024 kill_i=1 in CALC, FIX or DONE SHALL force IDLE on the next edge with v_o=0; kill_i in IDLE SHALL block acceptance only.
REQ-025 yumi_i without v_o is illegal; the design SHALL ignore it, and the bench SHALL assert against it.

Reset
REQ-026 Assertion of reset_n_i=0 SHALL asynchronously force IDLE, with v_o=0, ready_o=1 after release, result_o=0, rd_o=0 and counter=0, including mid-CALC.
REQ-027 Operand and shift registers need not be reset; no output SHALL depend on them outside DONE.

Configuration
REQ-028 Macro VANILLA_IDIV_ZERO_FASTPATH_EN: when defined, an accept with rs2=0 SHALL skip CALC and FIX and enter DONE directly, so v_o rises 1 cycle after accept with the REQ-022 results.
REQ-029 When the macro is undefined, divide-by-zero SHALL take the full width_p+2 latency and produce the same REQ-022 results.

Verification
REQ-030 eDIVU rs1=100, rs2=7 -> v_o at accept+34, result_o=14; eREMU with the same operands -> 2.
REQ-031 eDIV rs1=-100 (0xFFFFFF9C), rs2=7 -> 0xFFFFFFF2 (-14); eREM -> 0xFFFFFFFE (-2).
REQ-032 eDIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; eREM -> 0.
REQ-033 eDIV rs1=-5, rs2=0 -> 0xFFFFFFFF; eREM -> 0xFFFFFFFB; latency 34 without the macro and 1 with it.
REQ-034 kill_i pulsed at accept+10 -> v_o stays 0, ready_o=1 at accept+11; the next request, eDIVU 9/3 with rd=5, completes with result 3 and rd_o=5.
REQ-035 reset_n_i dropped at accept+5 -> v_o=0 immediately; after release ready_o=1 and the next request produces correct results. Additionally, holding yumi_i=0 for 10 cycles keeps v_o=1 with a stable result.
